// File: rtl/vram_slot_arbiter.sv
// vram_slot_arbiter: 16-phase RAM time-slot scheduler shared by
// gate-array video fetch and the Z80 CPU.
//
// Ports:
//   clk, RESET_N (async, active low), cen_16 (16 MHz enable)
//   vid_addr           video word address
//   cpu_req/we/addr/wdata  CPU request, sampled on acceptance
//   cpu_rdata, cpu_ready   read data and wait handshake (0 = wait)
//   ram_addr/we/wdata/rdata  RAM port (rdata combinational)
//   vid_data, vid_valid    {odd, even} video word and update pulse
//
// Option: define VRAM_ARB_DUAL_CPU_EN to add a second CPU slot
// at phase (CPU_PHASE + 4) mod 16.
//
// Timing: a slot starting at phase P is entered on the tick that
// sees phase P and ends ACC_LEN ticks later; the ending tick
// captures ram_rdata, so the RAM sees a stable address for
// ACC_LEN full ticks.

module vram_slot_arbiter #(
    parameter int VID0_PHASE = 0,
    parameter int VID1_PHASE = 4,
    parameter int CPU_PHASE  = 8,
    parameter int ACC_LEN    = 2
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        cen_16,
    input  logic [14:0] vid_addr,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [15:0] vid_data,
    output logic        vid_valid
);

    typedef enum logic [2:0] {
        IDLE,
        VID0,
        VID1,
        CPU,
        CPU_DONE
    } state_t;

    localparam logic [3:0] PH_V0 = 4'(VID0_PHASE);
    localparam logic [3:0] PH_V1 = 4'(VID1_PHASE);
    localparam logic [3:0] PH_C0 = 4'(CPU_PHASE);
    localparam logic [1:0] LAST  = 2'(ACC_LEN - 1);

    state_t      state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [14:0] lat_q, lat_d;
    logic        pend_q, pend_d;
    logic        done_q, done_d;
    logic        cwe_q, cwe_d;
    logic [15:0] caddr_q, caddr_d;
    logic [7:0]  cwd_q, cwd_d;

    logic [7:0]  cpu_rdata_d;
    logic        cpu_ready_d;
    logic [15:0] ram_addr_d;
    logic        ram_we_d;
    logic [7:0]  ram_wdata_d;
    logic [15:0] vid_data_d;
    logic        vid_valid_d;

    logic        cpu_slot;
    logic        accept;
    logic        busy;
    logic        last;

`ifdef VRAM_ARB_DUAL_CPU_EN
    localparam logic [3:0] PH_C1 = 4'((CPU_PHASE + 4) % 16);
    assign cpu_slot = (phase_q == PH_C0) || (phase_q == PH_C1);
`else
    assign cpu_slot = (phase_q == PH_C0);
`endif

    // done_q is the CPU_DONE gate; it is kept as its own flag so
    // that a slot entered on the same tick cannot lose it.
    assign accept = cen_16 && cpu_req && !done_q && !pend_q;
    assign busy   = (state_q == VID0) || (state_q == VID1) ||
                    (state_q == CPU);
    assign last   = busy && (cnt_q == LAST);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        pend_d      = pend_q;
        done_d      = done_q;
        cwe_d       = cwe_q;
        caddr_d     = caddr_q;
        cwd_d       = cwd_q;
        cpu_rdata_d = cpu_rdata;
        cpu_ready_d = cpu_ready;
        ram_addr_d  = ram_addr;
        ram_we_d    = ram_we;
        ram_wdata_d = ram_wdata;
        vid_data_d  = vid_data;
        vid_valid_d = 1'b0;

        if (cen_16) begin
            phase_d = phase_q + 4'd1;

            if (done_q && !cpu_req) begin
                done_d = 1'b0;
            end
            if (state_q == CPU_DONE && !cpu_req) begin
                state_d = IDLE;
            end

            if (accept) begin
                pend_d      = 1'b1;
                cwe_d       = cpu_we;
                caddr_d     = cpu_addr;
                cwd_d       = cpu_wdata;
                cpu_ready_d = 1'b0;
            end

            if (busy) begin
                cnt_d = cnt_q + 2'd1;
            end

            if (last) begin
                cnt_d = 2'd0;
                case (state_q)
                    VID0: begin
                        vid_data_d[7:0] = ram_rdata;
                        state_d         = IDLE;
                    end
                    VID1: begin
                        vid_data_d[15:8] = ram_rdata;
                        vid_valid_d      = 1'b1;
                        state_d          = IDLE;
                    end
                    CPU: begin
                        if (!cwe_q) begin
                            cpu_rdata_d = ram_rdata;
                        end
                        ram_we_d    = 1'b0;
                        cpu_ready_d = 1'b1;
                        pend_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = CPU_DONE;
                    end
                    default: ;
                endcase
            end

            // Slot entries win over the exit above, which lets
            // back-to-back windows share a boundary tick.
            if (phase_q == PH_V0) begin
                lat_d      = vid_addr;
                state_d    = VID0;
                cnt_d      = 2'd0;
                ram_addr_d = {vid_addr, 1'b0};
                ram_we_d   = 1'b0;
            end else if (phase_q == PH_V1) begin
                state_d    = VID1;
                cnt_d      = 2'd0;
                ram_addr_d = {lat_q, 1'b1};
                ram_we_d   = 1'b0;
            end else if (cpu_slot && (pend_q || accept)) begin
                state_d     = CPU;
                cnt_d       = 2'd0;
                ram_addr_d  = accept ? cpu_addr : caddr_q;
                ram_we_d    = accept ? cpu_we : cwe_q;
                ram_wdata_d = accept ? cpu_wdata : cwd_q;
            end
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            phase_q   <= 4'd0;
            cnt_q     <= 2'd0;
            lat_q     <= 15'd0;
            pend_q    <= 1'b0;
            done_q    <= 1'b0;
            cwe_q     <= 1'b0;
            caddr_q   <= 16'd0;
            cwd_q     <= 8'd0;
            cpu_rdata <= 8'd0;
            cpu_ready <= 1'b1;
            ram_addr  <= 16'd0;
            ram_we    <= 1'b0;
            ram_wdata <= 8'd0;
            vid_data  <= 16'd0;
            vid_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            pend_q    <= pend_d;
            done_q    <= done_d;
            cwe_q     <= cwe_d;
            caddr_q   <= caddr_d;
            cwd_q     <= cwd_d;
            cpu_rdata <= cpu_rdata_d;
            cpu_ready <= cpu_ready_d;
            ram_addr  <= ram_addr_d;
            ram_we    <= ram_we_d;
            ram_wdata <= ram_wdata_d;
            vid_data  <= vid_data_d;
            vid_valid <= vid_valid_d;
        end
    end

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// tb_vram_slot_arbiter: bench for vram_slot_arbiter with a RAM,
// a slot-level reference model and directed scenarios.

module tb_vram_slot_arbiter;

    localparam int V0  = 0;
    localparam int V1  = 4;
    localparam int CP  = 8;
    localparam int ACC = 2;
`ifdef VRAM_ARB_DUAL_CPU_EN
    localparam int WR_LAT = 4 + ACC - 1;
`else
    localparam int WR_LAT = 16 + ACC - 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen_16 = 1'b0;
    logic [14:0] vid_addr = 15'h1234;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [7:0]  cpu_wdata = 8'h0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [15:0] vid_data;
    logic        vid_valid;

    logic [7:0]  ram   [65536];
    logic [7:0]  mem_m [65536];

    int n_pass = 0;
    int n_total = 0;

    vram_slot_arbiter #(
        .VID0_PHASE(V0),
        .VID1_PHASE(V1),
        .CPU_PHASE (CP),
        .ACC_LEN   (ACC)
    ) dut (
        .clk      (clk),
        .RESET_N  (rst_n),
        .cen_16   (cen_16),
        .vid_addr (vid_addr),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .vid_data (vid_data),
        .vid_valid(vid_valid)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            cen_16 = ~cen_16;
        end
    end

    // RAM: asynchronous read, write committed when the strobe
    // ends normally (a reset-aborted strobe writes nothing).
    assign ram_rdata = ram[ram_addr];
    always @(negedge ram_we) begin
        if (rst_n) ram[ram_addr] = ram_wdata;
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Reference model: slot schedule by phase arithmetic.
    logic [3:0]  m_phase;
    logic [14:0] m_lat;
    logic        m_pend, m_gate, m_busy;
    logic [3:0]  m_end;
    logic        m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wd;
    logic [15:0] e_addr;
    logic        e_we;
    logic [7:0]  e_rdata;
    logic        e_ready;
    logic [15:0] e_vid;
    logic        e_valid;

    function automatic bit is_cpu_slot(input logic [3:0] p);
`ifdef VRAM_ARB_DUAL_CPU_EN
        return (p == 4'(CP)) || (p == 4'((CP + 4) % 16));
`else
        return p == 4'(CP);
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] p;
        bit g_old, acc;
        if (!rst_n) begin
            m_phase = 0; m_lat = 0; m_pend = 0;
            m_gate = 0; m_busy = 0; m_end = 0;
            m_we = 0; m_addr = 0; m_wd = 0;
            e_addr = 0; e_we = 0; e_rdata = 0;
            e_ready = 1; e_vid = 0; e_valid = 0;
        end else begin
            e_valid = 0;
            if (cen_16) begin
                p = m_phase;
                g_old = m_gate;
                acc = cpu_req && !m_gate && !m_pend;
                if (g_old && !cpu_req) m_gate = 0;
                if (acc) begin
                    m_pend = 1; m_we = cpu_we;
                    m_addr = cpu_addr; m_wd = cpu_wdata;
                    e_ready = 0;
                end
                if (m_busy && p == m_end) begin
                    if (m_we) mem_m[m_addr] = m_wd;
                    else e_rdata = mem_m[m_addr];
                    e_we = 0; e_ready = 1;
                    m_pend = 0; m_busy = 0; m_gate = 1;
                end
                if (p == 4'((V0 + ACC) % 16))
                    e_vid[7:0] = mem_m[{m_lat, 1'b0}];
                if (p == 4'((V1 + ACC) % 16)) begin
                    e_vid[15:8] = mem_m[{m_lat, 1'b1}];
                    e_valid = 1;
                end
                if (p == 4'(V0)) begin
                    m_lat = vid_addr;
                    e_addr = {vid_addr, 1'b0};
                end
                if (p == 4'(V1)) e_addr = {m_lat, 1'b1};
                if (is_cpu_slot(p) && m_pend && !m_busy) begin
                    m_busy = 1;
                    m_end = p + 4'(ACC);
                    e_addr = m_addr;
                    e_we = m_we;
                end
                m_phase = p + 4'd1;
            end
        end
    end

    always @(negedge clk) begin
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        chk("cpu_ready", 32'(cpu_ready), 32'(e_ready));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata));
        chk("vid_data", 32'(vid_data), 32'(e_vid));
        chk("vid_valid", 32'(vid_valid), 32'(e_valid));
        if (e_we) chk("ram_wdata", 32'(ram_wdata), 32'(m_wd));
    end

    // Wait until the next tick will see phase p.
    task automatic wait_phase(input logic [3:0] p);
        int k;
        k = 0;
        do begin
            @(negedge clk); #1;
            k++;
        end while (!(cen_16 && m_phase == p) && k < 200);
        if (k >= 200) chk("wait_phase_timeout", 32'(k), 32'(0));
    endtask

    // Ticks after which cpu_ready reads 0, until it returns to 1.
    task automatic ready_lat(output int n);
        n = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (cen_16) begin
                if (!cpu_ready) n++;
                else break;
            end
        end
    endtask

    initial begin
        int lat, extra;
        bit ok;
        ok = 1;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                int sa, sb;
                sa = (a == 0) ? V0 : (a == 1) ? V1 :
                     (a == 2) ? CP : (CP + 4) % 16;
                sb = (b == 0) ? V0 : (b == 1) ? V1 :
                     (b == 2) ? CP : (CP + 4) % 16;
                if (a != b && ((sb - sa) & 15) < ACC) ok = 0;
            end
        end
        assert (ok) else $fatal(1, "slot windows overlap");

        for (int i = 0; i < 65536; i++) begin
            ram[i] = 8'h00;
            mem_m[i] = 8'h00;
        end
        ram[16'h2468] = 8'hAA; mem_m[16'h2468] = 8'hAA;
        ram[16'h2469] = 8'h55; mem_m[16'h2469] = 8'h55;
        ram[16'h4000] = 8'h3C; mem_m[16'h4000] = 8'h3C;

        repeat (4) @(negedge clk);
        #1;
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_ready", 32'(cpu_ready), 32'h1);
        chk("rst_vid_data", 32'(vid_data), 32'h0);
        chk("rst_ram_we", 32'(ram_we), 32'h0);
        rst_n = 1'b1;

        wait_phase(4'd1);
        chk("v0_addr", 32'(ram_addr), 32'h2468);
        wait_phase(4'd5);
        chk("v1_addr", 32'(ram_addr), 32'h2469);
        wait_phase(4'd6);
        @(negedge clk); #1;
        chk("vid_valid_pulse", 32'(vid_valid), 32'h1);
        chk("vid_word", 32'(vid_data), 32'h55AA);

        // CPU read at its own slot: minimum latency.
        wait_phase(4'd8);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4000;
        ready_lat(lat);
        chk("rd_latency", 32'(lat), 32'(ACC));
        chk("rd_data", 32'(cpu_rdata), 32'h3C);
        extra = 0;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1;
            if (cen_16 && !cpu_ready) extra++;
        end
        chk("no_second_access", 32'(extra), 32'h0);
        cpu_req = 0;

        // Video address moved between the two byte fetches.
        wait_phase(4'd1);
        vid_addr = 15'h0ABC;
        wait_phase(4'd5);
        chk("v1_latched", 32'(ram_addr), 32'h2469);
        wait_phase(4'd15);
        vid_addr = 15'h1234;

        // CPU write one tick after its slot: maximum latency.
        wait_phase(4'd9);
        cpu_req = 1; cpu_we = 1;
        cpu_addr = 16'hC000; cpu_wdata = 8'h5A;
        ready_lat(lat);
        chk("wr_latency", 32'(lat), 32'(WR_LAT));
        cpu_req = 0; cpu_we = 0;
        @(negedge clk); #1;
        chk("wr_ram", 32'(ram[16'hC000]), 32'h5A);

        // Reset in the middle of a CPU write.
        wait_phase(4'd8);
        cpu_req = 1; cpu_we = 1;
        cpu_addr = 16'h8000; cpu_wdata = 8'h77;
        wait_phase(4'd9);
        chk("abort_we_before", 32'(ram_we), 32'h1);
        rst_n = 0;
        #1;
        chk("abort_we", 32'(ram_we), 32'h0);
        chk("abort_ready", 32'(cpu_ready), 32'h1);
        cpu_req = 0; cpu_we = 0;
        @(negedge clk); #1;
        rst_n = 1;
        chk("abort_ram", 32'(ram[16'h8000]), 32'h00);
        wait_phase(4'd1);
        chk("abort_phase0", 32'(ram_addr), 32'h2468);
        wait_phase(4'd8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
